regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/registers_types.sv | 13 +
 rtl/rr_arbiter.sv | 43 ++++
 rtl/regfile_wb_arbiter.sv | 77 +++++++
 tb/tb_regfile_wb_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/registers_types.sv
// Shared register-file types: register width and the writeback request record.
package registers_types;

  typedef logic [63:0] double_word;

  localparam int unsigned NUM_WB_SRC = 3;

  typedef struct packed {
    logic [4:0] rd;
    double_word data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters, priority starting at an internal pointer.
module rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gidx;
  logic             found;
  int unsigned      idx;

  // Grant is masked during reset so no transfer can complete in a reset cycle.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    if (!rst) begin
      for (int unsigned k = 0; k < N; k++) begin
        idx = (32'(ptr) + k) % N;
        if (!found && req[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          gidx       = PTR_W'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (found)
      ptr <= (gidx == PTR_W'(N - 1)) ? '0 : gidx + 1'b1;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates writeback sources onto the register-file write port and tracks in-flight writes.
module regfile_wb_arbiter
  import registers_types::*;
#(
  parameter int unsigned NUM_SRC = NUM_WB_SRC
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_SRC-1:0]              wb_valid,
  input  logic [NUM_SRC-1:0][4:0]         wb_rd,
  input  logic [NUM_SRC-1:0][63:0]        wb_data,
  output logic [NUM_SRC-1:0]              wb_ready,
  input  logic                            rsv_valid,
  input  logic [4:0]                      rsv_rd,
  output logic                            rsv_ready,
  output logic                            w_enable,
  output logic [4:0]                      write_entry,
  output double_word                      write_value,
  output logic [31:0]                     busy
);

  wb_req_t     sel;
  logic        xfer;
  logic        rsv_fire;
  logic [31:0] busy_next;

  rr_arbiter #(.N(NUM_SRC)) u_rr_arbiter (
    .clk   (clk),
    .rst   (rst),
    .req   (wb_valid),
    .grant (wb_ready)
  );

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (wb_ready[i]) begin
        sel.rd   = wb_rd[i];
        sel.data = wb_data[i];
      end
    end
  end

  assign xfer = |(wb_valid & wb_ready);

  // A same-cycle writeback to the reserved register frees it, so the reservation may proceed.
  assign rsv_ready = !rst && rsv_valid &&
                     ((rsv_rd == 5'd0) || !busy[rsv_rd] || (xfer && (sel.rd == rsv_rd)));
  assign rsv_fire  = rsv_valid && rsv_ready;

  // Clear before set: a simultaneous reserve of the same register keeps the bit high.
  always_comb begin
    busy_next = busy;
    if (xfer)
      busy_next[sel.rd] = 1'b0;
    if (rsv_fire && (rsv_rd != 5'd0))
      busy_next[rsv_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= '0;
      w_enable    <= 1'b0;
      write_entry <= '0;
      write_value <= '0;
    end else begin
      busy     <= busy_next;
      w_enable <= xfer && (sel.rd != 5'd0);
      if (xfer && (sel.rd != 5'd0)) begin
        write_entry <= sel.rd;
        write_value <= sel.data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and random checks of regfile_wb_arbiter against a behavioural reference model.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;

  localparam int N = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N-1:0]          wb_valid;
  logic [N-1:0][4:0]     wb_rd;
  logic [N-1:0][63:0]    wb_data;
  logic [N-1:0]          wb_ready;
  logic                  rsv_valid;
  logic [4:0]            rsv_rd;
  logic                  rsv_ready;
  logic                  w_enable;
  logic [4:0]            write_entry;
  logic [63:0]           write_value;
  logic [31:0]           busy;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          m_ptr;
  bit [31:0]   m_busy;
  bit          m_we;
  bit [4:0]    m_entry;
  bit [63:0]   m_value;
  int          last_grant;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NUM_SRC(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_ready    (wb_ready),
    .rsv_valid   (rsv_valid),
    .rsv_rd      (rsv_rd),
    .rsv_ready   (rsv_ready),
    .w_enable    (w_enable),
    .write_entry (write_entry),
    .write_value (write_value),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check combinational outputs, advance model, check registered outputs.
  task automatic step(input logic r, input logic [N-1:0] wv,
                      input logic [N-1:0][4:0] rds, input logic [N-1:0][63:0] ds,
                      input logic rv, input logic [4:0] rrd);
    int g;
    logic [N-1:0] exp_ready;
    logic exp_rsv;
    rst = r; wb_valid = wv; wb_rd = rds; wb_data = ds; rsv_valid = rv; rsv_rd = rrd;
    #1;
    g = -1;
    if (!r)
      for (int k = 0; k < N; k++)
        if (g < 0 && wv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    exp_ready = (g >= 0) ? N'(1 << g) : '0;
    exp_rsv = !r && rv && (rrd == 0 || !m_busy[rrd] || (g >= 0 && rds[g] == rrd));
    check("wb_ready", 64'(wb_ready), 64'(exp_ready));
    check("rsv_ready", 64'(rsv_ready), 64'(exp_rsv));
    last_grant = g;
    if (r) begin
      m_ptr = 0; m_busy = '0; m_we = 0; m_entry = '0; m_value = '0;
    end else begin
      m_we = 0;
      if (g >= 0) begin
        m_ptr = (g + 1) % N;
        if (rds[g] != 0) begin
          m_busy[rds[g]] = 1'b0;
          m_we = 1; m_entry = rds[g]; m_value = ds[g];
        end
      end
      if (exp_rsv && rrd != 0) m_busy[rrd] = 1'b1;
    end
    @(posedge clk);
    #1;
    check("w_enable", 64'(w_enable), 64'(m_we));
    check("busy", 64'(busy), 64'(m_busy));
    check("write_entry", 64'(write_entry), 64'(m_entry));
    check("write_value", write_value, m_value);
  endtask

  logic [N-1:0][4:0]  rds;
  logic [N-1:0][63:0] ds;

  initial begin
    m_ptr = 0; m_busy = '0; m_we = 0; m_entry = '0; m_value = '0; last_grant = -1;
    rds = '0; ds = '0;

    step(1, '0, rds, ds, 0, 0);
    step(1, '0, rds, ds, 0, 0);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_we", 64'(w_enable), 64'h0);

    // All sources valid with rd 1/2/3: grants rotate 0,1,2,0
    rds[0] = 5'd1; rds[1] = 5'd2; rds[2] = 5'd3;
    ds[0] = 64'h111; ds[1] = 64'h222; ds[2] = 64'h333;
    step(0, 3'b111, rds, ds, 0, 0); check("rr_grant0", 64'(last_grant), 64'd0);
    check("rr_entry0", 64'(write_entry), 64'd1);
    step(0, 3'b111, rds, ds, 0, 0); check("rr_grant1", 64'(last_grant), 64'd1);
    check("rr_entry1", 64'(write_entry), 64'd2);
    step(0, 3'b111, rds, ds, 0, 0); check("rr_grant2", 64'(last_grant), 64'd2);
    check("rr_entry2", 64'(write_entry), 64'd3);
    step(0, 3'b111, rds, ds, 0, 0); check("rr_grant3", 64'(last_grant), 64'd0);

    // Reserve x5 twice; second blocked until source 1 writes 0xDEAD
    step(0, '0, rds, ds, 1, 5'd5);
    check("busy5_set", 64'(busy[5]), 64'd1);
    rsv_valid = 1; rsv_rd = 5'd5; wb_valid = '0; #1;
    check("rsv_again_blocked", 64'(rsv_ready), 64'd0);
    step(0, '0, rds, ds, 1, 5'd5);
    rds[1] = 5'd5; ds[1] = 64'hDEAD;
    step(0, 3'b010, rds, ds, 0, 0);
    check("busy5_clear", 64'(busy[5]), 64'd0);
    check("dead_value", write_value, 64'hDEAD);

    // Same-cycle reserve and writeback of x7: reservation wins
    step(0, '0, rds, ds, 1, 5'd7);
    rds[0] = 5'd7; ds[0] = 64'h7777;
    step(0, 3'b001, rds, ds, 1, 5'd7);
    check("busy7_kept", 64'(busy[7]), 64'd1);
    check("entry7", 64'(write_entry), 64'd7);
    rds[0] = 5'd7;
    step(0, 3'b001, rds, ds, 0, 0);

    // Writeback to x0: handshake completes, no write strobe
    rds[2] = 5'd0; ds[2] = 64'hFFFF;
    step(0, 3'b100, rds, ds, 0, 0);
    check("x0_grant", 64'(last_grant), 64'd2);
    check("x0_no_we", 64'(w_enable), 64'd0);

    // Busy = 0xF0 then reset with source 2 valid
    for (int r = 4; r < 8; r++) step(0, '0, rds, ds, 1, 5'(r));
    check("busy_f0", 64'(busy), 64'hF0);
    rds[2] = 5'd9; ds[2] = 64'h99;
    step(0, 3'b100, rds, ds, 0, 0);
    step(1, 3'b100, rds, ds, 0, 0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_we", 64'(w_enable), 64'h0);
    rds[0] = 5'd1; rds[1] = 5'd2; rds[2] = 5'd3;
    step(0, 3'b111, rds, ds, 0, 0);
    check("post_rst_grant", 64'(last_grant), 64'd0);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        rds[i] = 5'($urandom_range(0, 31));
        ds[i]  = {$urandom, $urandom};
      end
      step(($urandom_range(0, 49) == 0), N'($urandom), rds, ds,
           1'($urandom), 5'($urandom_range(0, 31)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
